set_cmd_dispatcher: RTL
=======================

Name: set_cmd_dispatcher

Overview:
Upstream command stage for the SET circle-candidate counter core. Buffers host commands (centres, radii, mode, tag) in a small FIFO and issues them one at a time to the core with a single-cycle enable. Waits for the core's valid pulse, captures the candidate count, and returns it with the command tag over a valid/ready result port. A watchdog covers a core that never completes.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TO_W, 10, watchdog counter width
TIMEOUT, 1023, WAIT-state cycles before abort; must be < 2^TO_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each
cmd_radius  in  12  {r1,r2,r3}, 4 bits each
cmd_mode  in  2  set-operation mode 0..3
cmd_tag  in  4  host-side identifier, returned with the result
set_en  out  1  one-cycle start pulse to core
set_central  out  24  to core, held stable from issue until completion
set_radius  out  12  to core, held stable from issue until completion
set_mode  out  2  to core, held stable from issue until completion
set_busy  in  1  core busy
set_valid  in  1  core one-cycle done pulse
set_candidate  in  8  core count; sampled only with set_valid
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_candidate  out  8  captured count
res_tag  out  4  tag of the completed command
res_timeout  out  1  result produced by watchdog abort
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset: asynchronous on rst. FIFO flushed; FSM to IDLE. set_en, set_central, set_radius, set_mode, res_valid, res_candidate, res_tag and res_timeout reset to 0. cmd_ready=1 and idle=1 out of reset.
- Reset mid-operation: any in-flight command and any pending result are discarded. No res_valid is produced for them.
- FIFO: cmd_ready = !full (combinational). A push occurs when cmd_valid && cmd_ready. A pop occurs on entry to ISSUE.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - cmd_valid while full is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- All set_* and res_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE -> ISSUE when FIFO non-empty && !set_busy && !res_valid.
  - IDLE -> ISSUE transition: head fields are loaded into set_central/set_radius/set_mode and the tag register; the entry is popped; set_en is set to 1.
  - ISSUE: set_en is high for exactly this one cycle. Watchdog is cleared. Next state is WAIT.
  - WAIT: watchdog increments each cycle.
    - set_valid=1: capture set_candidate into res_candidate; res_tag = tag; res_timeout=0; res_valid=1; go to RESP.
    - Otherwise, watchdog==TIMEOUT: res_candidate=0; res_timeout=1; res_valid=1; go to RESP.
    - set_valid in the same cycle as the timeout wins; res_timeout=0.
  - RESP: res_* fields are held stable while res_valid && !res_ready. When res_ready=1, res_valid is cleared and the FSM goes to IDLE.
- set_valid outside WAIT is ignored and changes no state.
- Latency: a command pushed in cycle t into an empty, idle block drives set_en=1 in cycle t+2. res_valid rises the cycle after set_valid is sampled.
- Throughput: at most one command in flight. After res_ready is accepted, the next set_en can assert 2 cycles later.
- idle = (FSM==IDLE) && FIFO empty.

Test Plan:
- Single command: mode=0, central=0x440000, radius=0x300, tag=5; core stub pulses set_valid 70 cycles after set_en with candidate=0x1D, res_ready=1. Required: exactly one set_en pulse 2 cycles after the push; set_central/set_radius/set_mode stable throughout; res_valid for 1 cycle with res_candidate=0x1D, res_tag=5, res_timeout=0; idle=1 afterwards.
- Fill/backpressure: push 6 commands back-to-back with res_ready=0; core completes the first. Required: 5 commands accepted (1 issued plus 4 buffered); cmd_ready=0 at the 6th; res_valid held with stable fields; no second set_en until res_ready=1.
- Ordering: 4 commands with tags 1..4 and stubbed candidates 10,20,30,40. Required: results return in order, tag/candidate pairs 1/10, 2/20, 3/30, 4/40; no FIFO wrap corruption across 3 fill/drain passes.
- Timeout: core never asserts set_valid. Required: exactly 1023 WAIT cycles then res_valid with res_candidate=0, res_timeout=1; the next command then issues normally.
- Stray/simultaneous: set_valid pulsed while in IDLE is ignored with no result; set_valid on the exact timeout cycle gives res_timeout=0 with the captured candidate; set_busy=1 in IDLE blocks issue until it drops.
- Reset mid-WAIT: assert rst with 2 commands buffered. Required: outputs return to reset values, cmd_ready=1, idle=1, and no res_valid for the discarded commands.

Source files
------------

// File: rtl/set_cmd_dispatcher_if.sv
// rtl/set_cmd_dispatcher_if.sv - host command, core control and result signal bundle for set_cmd_dispatcher
interface set_cmd_dispatcher_if;
    // Host command port
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_central;
    logic [11:0] cmd_radius;
    logic [1:0]  cmd_mode;
    logic [3:0]  cmd_tag;
    // SET core control
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    // Result port
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic [3:0]  res_tag;
    logic        res_timeout;
    logic        idle;

    // Dispatcher side
    modport master (
        input  cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        output cmd_ready,
        output set_en, set_central, set_radius, set_mode,
        input  set_busy, set_valid, set_candidate,
        output res_valid, res_candidate, res_tag, res_timeout,
        input  res_ready,
        output idle
    );

    // Host and core side
    modport slave (
        output cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        input  cmd_ready,
        input  set_en, set_central, set_radius, set_mode,
        output set_busy, set_valid, set_candidate,
        input  res_valid, res_candidate, res_tag, res_timeout,
        output res_ready,
        input  idle
    );
endinterface

// File: rtl/set_cmd_dispatcher.sv
// rtl/set_cmd_dispatcher.sv - buffers host commands, issues them to the SET core and returns tagged results
module set_cmd_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_W       = 10,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    set_cmd_dispatcher_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 42;  // {central[23:0], radius[11:0], mode[1:0], tag[3:0]}

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [3:0]      tag_q;
    logic [TO_W-1:0] wd_cnt;
    logic [TO_W-1:0] wd_inc;
    logic            wd_expired;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = bus.cmd_valid && !full;
    // Issue only when the core is free and no result is still waiting for the host
    assign pop        = (state == S_IDLE) && !empty && !bus.set_busy && !bus.res_valid;
    assign head       = fifo_mem[rd_ptr];
    // The watchdog counts WAIT cycles including the current one
    assign wd_inc     = wd_cnt + 1'b1;
    assign wd_expired = (wd_inc == TO_W'(TIMEOUT));

    assign bus.cmd_ready = !full;
    assign bus.idle      = (state == S_IDLE) && empty;

    // Command storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_central, bus.cmd_radius, bus.cmd_mode, bus.cmd_tag};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Issue/wait/respond sequencer with registered core and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            tag_q             <= '0;
            wd_cnt            <= '0;
            bus.set_en        <= 1'b0;
            bus.set_central   <= '0;
            bus.set_radius    <= '0;
            bus.set_mode      <= '0;
            bus.res_valid     <= 1'b0;
            bus.res_candidate <= '0;
            bus.res_tag       <= '0;
            bus.res_timeout   <= 1'b0;
        end else begin
            bus.set_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.set_central <= head[41:18];
                        bus.set_radius  <= head[17:6];
                        bus.set_mode    <= head[5:4];
                        tag_q           <= head[3:0];
                        bus.set_en      <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A real completion beats a watchdog expiry in the same cycle
                    if (bus.set_valid) begin
                        bus.res_candidate <= bus.set_candidate;
                        bus.res_tag       <= tag_q;
                        bus.res_timeout   <= 1'b0;
                        bus.res_valid     <= 1'b1;
                        state             <= S_RESP;
                    end else if (wd_expired) begin
                        bus.res_candidate <= '0;
                        bus.res_tag       <= tag_q;
                        bus.res_timeout   <= 1'b1;
                        bus.res_valid     <= 1'b1;
                        state             <= S_RESP;
                    end else begin
                        wd_cnt <= wd_inc;
                    end
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
